// File: rtl/i2s_pkg.sv
// i2s_pkg: constants shared by the I2S master shift register and its clock
// generator.
//   - Frame geometry: a 64-bit stereo frame made of two 32-bit slots.
//     Left occupies [63:32] and right occupies [31:0].
//   - Slot indices of the decision points:
//     - SLOT_LOAD: playback load and ack rise.
//     - SLOT_XFER: capture transfer and write rise.
//     - SLOT_XFER_END: write strobe fall.
package i2s_pkg;

  localparam int unsigned SLOT_BITS  = 32;
  localparam int unsigned FRAME_BITS = 2 * SLOT_BITS;
  localparam int unsigned LEFT_MSB   = FRAME_BITS - 1;
  localparam int unsigned RIGHT_MSB  = SLOT_BITS - 1;

  typedef logic [5:0] slot_t;

  localparam slot_t SLOT_LOAD     = 6'd0;
  localparam slot_t SLOT_XFER     = 6'd1;
  localparam slot_t SLOT_XFER_END = 6'd2;

endpackage

// File: rtl/i2s_clkgen.sv
// i2s_clkgen: divides clk down to the I2S bit clock and tracks the frame slot.
//   clk, reset_n       : interface clock and async active-low reset
//   bclk               : bit clock. It toggles every BCLK_DIV clk cycles.
//   lrclk              : word select, taken from slot_cnt[5]
//   rise_evt, fall_evt : high for the clk cycle whose closing edge drives
//                        bclk 0->1 or 1->0
//   slot_cnt           : current slot (0..63). It advances on each fall.
//                        Its reset value is 63, so the first fall enters slot 0.
module i2s_clkgen
  import i2s_pkg::*;
#(
  parameter int unsigned BCLK_DIV = 4
) (
  input  logic  clk,
  input  logic  reset_n,
  output logic  bclk,
  output logic  lrclk,
  output logic  rise_evt,
  output logic  fall_evt,
  output slot_t slot_cnt
);

  localparam int unsigned DIV_W = (BCLK_DIV > 2) ? $clog2(BCLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BCLK_DIV - 1);

  logic [DIV_W-1:0] div_q, div_d;
  logic             bclk_q, bclk_d;
  slot_t            slot_q, slot_d;
  logic             wrap;

  // The events are combinational, so that the top level's registers update
  // on the same clk edge that toggles bclk.
  always_comb begin
    wrap     = (div_q == DIV_LAST);
    rise_evt = wrap && !bclk_q;
    fall_evt = wrap && bclk_q;
    div_d    = wrap ? '0 : div_q + 1'b1;
    bclk_d   = wrap ? ~bclk_q : bclk_q;
    slot_d   = fall_evt ? slot_q + 1'b1 : slot_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div_q  <= '0;
      bclk_q <= 1'b0;
      slot_q <= '1;
    end else begin
      div_q  <= div_d;
      bclk_q <= bclk_d;
      slot_q <= slot_d;
    end
  end

  assign bclk     = bclk_q;
  assign lrclk    = slot_q[5];
  assign slot_cnt = slot_q;

endmodule

// File: rtl/i2s_shift_reg.sv
// i2s_shift_reg: I2S master serialiser and deserialiser, placed between the
// playback/capture FIFOs and the codec.
//   clk, reset_n           : interface clock and async active-low reset
//   i2s_playback_enable    : sampled at the slot-0 load
//   playback_fifo_data     : show-ahead FIFO head, {left, right}
//   i2s_playback_fifo_ack  : consume strobe, high for slot 0
//   i2s_capture_enable     : sampled at the slot-1 transfer
//   capture_fifo_data      : last captured frame, {left, right}
//   i2s_capture_fifo_write : write strobe, high for slot 1
//   bclk, lrclk            : I2S bit clock and word select
//   sdata_out, sdata_in    : serial playback and capture data
module i2s_shift_reg
  import i2s_pkg::*;
#(
  parameter int unsigned BCLK_DIV = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  i2s_playback_enable,
  input  logic [FRAME_BITS-1:0] playback_fifo_data,
  output logic                  i2s_playback_fifo_ack,
  input  logic                  i2s_capture_enable,
  output logic [FRAME_BITS-1:0] capture_fifo_data,
  output logic                  i2s_capture_fifo_write,
  output logic                  bclk,
  output logic                  lrclk,
  output logic                  sdata_out,
  input  logic                  sdata_in
);

  logic  rise_evt, fall_evt;
  slot_t slot_cnt, slot_entering;

  i2s_clkgen #(.BCLK_DIV(BCLK_DIV)) u_clkgen (
    .clk      (clk),
    .reset_n  (reset_n),
    .bclk     (bclk),
    .lrclk    (lrclk),
    .rise_evt (rise_evt),
    .fall_evt (fall_evt),
    .slot_cnt (slot_cnt)
  );

  logic [FRAME_BITS-1:0] play_q, play_d;
  logic [FRAME_BITS-1:0] cap_sh_q, cap_sh_d;
  logic [FRAME_BITS-1:0] cap_data_q, cap_data_d;
  logic                  sdo_q, sdo_d;
  logic                  ack_q, ack_d;
  logic                  wr_q, wr_d;
  logic                  primed_q, primed_d;

  assign slot_entering = slot_cnt + 1'b1;

  always_comb begin
    play_d     = play_q;
    cap_sh_d   = cap_sh_q;
    cap_data_d = cap_data_q;
    sdo_d      = sdo_q;
    ack_d      = ack_q;
    wr_d       = wr_q;
    primed_d   = primed_q;

    if (rise_evt) begin
      cap_sh_d = {cap_sh_q[FRAME_BITS-2:0], sdata_in};
    end

    if (fall_evt) begin
      // The slot-0 output is bit 0 of the old frame. The new frame is loaded
      // behind it, because the loaded word's MSB is only needed one slot later.
      sdo_d = play_q[LEFT_MSB];
      if (slot_entering == SLOT_LOAD) begin
        play_d = i2s_playback_enable ? playback_fifo_data : '0;
        ack_d  = i2s_playback_enable;
      end else begin
        play_d = {play_q[FRAME_BITS-2:0], 1'b0};
      end

      if (slot_entering == SLOT_XFER) begin
        ack_d = 1'b0;
        // The first slot-1 entry after reset only arms the transfer. The
        // frame in flight at that point is partial.
        if (primed_q && i2s_capture_enable) begin
          cap_data_d = cap_sh_q;
          wr_d       = 1'b1;
        end
        primed_d = 1'b1;
      end

      if (slot_entering == SLOT_XFER_END) begin
        wr_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      play_q     <= '0;
      cap_sh_q   <= '0;
      cap_data_q <= '0;
      sdo_q      <= 1'b0;
      ack_q      <= 1'b0;
      wr_q       <= 1'b0;
      primed_q   <= 1'b0;
    end else begin
      play_q     <= play_d;
      cap_sh_q   <= cap_sh_d;
      cap_data_q <= cap_data_d;
      sdo_q      <= sdo_d;
      ack_q      <= ack_d;
      wr_q       <= wr_d;
      primed_q   <= primed_d;
    end
  end

  assign sdata_out              = sdo_q;
  assign i2s_playback_fifo_ack  = ack_q;
  assign i2s_capture_fifo_write = wr_q;
  assign capture_fifo_data      = cap_data_q;

endmodule
